// File: rtl/dunit_loader.sv
// Debug-unit program loader: packs UART bytes MSB-first into 32-bit words and
// writes them into the fetch-stage instruction memory, gating the pipeline clock.
module dunit_loader #(
    parameter int          NB_REG    = 32,
    parameter int          NB_WIDHT  = 9,
    parameter int          NB_BYTE   = 8,
    parameter logic [31:0] HALT_WORD = 32'hFFFFFFFF
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_start_load,
    input  logic [NB_BYTE-1:0]  i_rx_data,
    input  logic                i_rx_valid,
    output logic                o_dunit_w_en,
    output logic [NB_WIDHT-1:0] o_dunit_addr,
    output logic [NB_REG-1:0]   o_dunit_data,
    output logic                o_dunit_clk_en,
    output logic                o_busy,
    output logic                o_load_done,
    output logic                o_overflow
);

    typedef enum logic [1:0] {IDLE, RECV, DONE, ERROR} state_t;

    localparam logic [NB_WIDHT-1:0] ADDR_LAST = {{(NB_WIDHT-2){1'b1}}, 2'b00};
    localparam logic [NB_WIDHT-1:0] ADDR_STEP = NB_WIDHT'(4);

    state_t              state_q,   state_d;
    logic [1:0]          cnt_q,     cnt_d;
    logic [NB_WIDHT-1:0] waddr_q,   waddr_d;
    logic [NB_REG-1:0]   shift_q,   shift_d;
    logic                w_en_q,    w_en_d;
    logic [NB_WIDHT-1:0] addr_q,    addr_d;
    logic [NB_REG-1:0]   data_q,    data_d;
    logic                clk_en_q,  clk_en_d;
    logic                busy_q,    busy_d;
    logic                done_q,    done_d;
    logic                ovf_q,     ovf_d;
    logic [NB_REG-1:0]   word;

    assign word = {shift_q[NB_REG-NB_BYTE-1:0], i_rx_data};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        waddr_d  = waddr_q;
        shift_d  = shift_q;
        w_en_d   = 1'b0;
        addr_d   = addr_q;
        data_d   = data_q;
        clk_en_d = clk_en_q;
        busy_d   = busy_q;
        done_d   = done_q;
        ovf_d    = ovf_q;

        // A restart beats everything, including a byte arriving on the same cycle.
        if (i_start_load) begin
            state_d  = RECV;
            cnt_d    = 2'd0;
            waddr_d  = '0;
            shift_d  = '0;
            clk_en_d = 1'b0;
            busy_d   = 1'b1;
            done_d   = 1'b0;
            ovf_d    = 1'b0;
        end else if (state_q == RECV && i_rx_valid) begin
            if (cnt_q == 2'd3) begin
                cnt_d   = 2'd0;
                shift_d = '0;
                w_en_d  = 1'b1;
                addr_d  = waddr_q;
                data_d  = word;
                if (word == HALT_WORD) begin
                    state_d  = DONE;
                    waddr_d  = waddr_q + ADDR_STEP;
                    clk_en_d = 1'b1;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                end else if (waddr_q == ADDR_LAST) begin
                    // Memory is full: stop here rather than wrap onto word 0.
                    state_d  = ERROR;
                    clk_en_d = 1'b0;
                    busy_d   = 1'b0;
                    ovf_d    = 1'b1;
                end else begin
                    waddr_d = waddr_q + ADDR_STEP;
                end
            end else begin
                cnt_d   = cnt_q + 2'd1;
                shift_d = word;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q  <= IDLE;
            cnt_q    <= 2'd0;
            waddr_q  <= '0;
            shift_q  <= '0;
            w_en_q   <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            clk_en_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            waddr_q  <= waddr_d;
            shift_q  <= shift_d;
            w_en_q   <= w_en_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            clk_en_q <= clk_en_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
        end
    end

    assign o_dunit_w_en   = w_en_q;
    assign o_dunit_addr   = addr_q;
    assign o_dunit_data   = data_q;
    assign o_dunit_clk_en = clk_en_q;
    assign o_busy         = busy_q;
    assign o_load_done    = done_q;
    assign o_overflow     = ovf_q;

endmodule

// File: tb/tb_dunit_loader.sv
// Bench for dunit_loader: expected writes are queued by the stimulus and
// popped by an independent write monitor; status flags are checked inline.
module tb_dunit_loader;

    logic       i_clk = 1'b0;
    logic       i_reset = 1'b0;
    logic       i_start_load = 1'b0;
    logic [7:0] i_rx_data = 8'h00;
    logic       i_rx_valid = 1'b0;
    logic       o_dunit_w_en;
    logic [8:0] o_dunit_addr;
    logic [31:0] o_dunit_data;
    logic       o_dunit_clk_en;
    logic       o_busy;
    logic       o_load_done;
    logic       o_overflow;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [8:0]  addr;
        logic [31:0] data;
    } wr_t;
    wr_t exp_q[$];

    dunit_loader dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_start_load   (i_start_load),
        .i_rx_data      (i_rx_data),
        .i_rx_valid     (i_rx_valid),
        .o_dunit_w_en   (o_dunit_w_en),
        .o_dunit_addr   (o_dunit_addr),
        .o_dunit_data   (o_dunit_data),
        .o_dunit_clk_en (o_dunit_clk_en),
        .o_busy         (o_busy),
        .o_load_done    (o_load_done),
        .o_overflow     (o_overflow)
    );

    always #5 i_clk = ~i_clk;

    // Write monitor: every strobe must match the oldest expected write.
    always @(negedge i_clk) begin
        if (i_reset && o_dunit_w_en) begin
            wr_t e;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write: got addr=%h data=%h, required no write",
                         o_dunit_addr, o_dunit_data);
            end else begin
                e = exp_q.pop_front();
                if (o_dunit_addr !== e.addr || o_dunit_data !== e.data) begin
                    failures++;
                    $display("FAIL write: got addr=%h data=%h, required addr=%h data=%h",
                             o_dunit_addr, o_dunit_data, e.addr, e.data);
                end else begin
                    $display("write ok addr=%h data=%h", o_dunit_addr, o_dunit_data);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end else begin
            $display("check ok %s = %h", name, act);
        end
    endtask

    task automatic chk_status(input string name, input logic busy, input logic clk_en,
                              input logic done, input logic ovf);
        chk(name, {28'd0, o_busy, o_dunit_clk_en, o_load_done, o_overflow},
                  {28'd0, busy, clk_en, done, ovf});
    endtask

    // All stimulus tasks start and end at posedge + 1.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic put(input logic [7:0] b);
        i_rx_data  = b;
        i_rx_valid = 1'b1;
        tick(1);
        i_rx_valid = 1'b0;
    endtask

    task automatic put_word(input logic [31:0] w, input bit gap);
        for (int k = 3; k >= 0; k--) begin
            put(w[8*k +: 8]);
            if (gap) tick(1);
        end
    endtask

    task automatic start_load();
        i_start_load = 1'b1;
        tick(1);
        i_start_load = 1'b0;
    endtask

    task automatic expect_wr(input logic [8:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
    endtask

    logic [31:0] w;

    initial begin
        // Reset state, asserted before any clock edge.
        #3;
        chk("reset_outputs", {20'd0, o_dunit_w_en, o_dunit_addr, 2'd0},
                             32'd0);
        chk("reset_data", o_dunit_data, 32'd0);
        chk_status("reset_status", 0, 0, 0, 0);
        @(negedge i_clk);
        i_reset = 1'b1;
        tick(1);

        // Bytes in IDLE must not produce a write.
        put_word(32'h12121212, 1'b0);
        tick(2);
        chk_status("idle_status", 0, 0, 0, 0);

        // Basic load with gaps between bytes.
        start_load();
        chk_status("recv_status", 1, 0, 0, 0);
        expect_wr(9'h000, 32'h20080005);
        put_word(32'h20080005, 1'b1);
        expect_wr(9'h004, 32'h8C090004);
        put_word(32'h8C090004, 1'b1);
        tick(2);

        // Back-to-back bytes every cycle.
        start_load();
        expect_wr(9'h000, 32'h01234567);
        expect_wr(9'h004, 32'h89ABCDEF);
        expect_wr(9'h008, 32'hDEADBEEF);
        put_word(32'h01234567, 1'b0);
        put_word(32'h89ABCDEF, 1'b0);
        put_word(32'hDEADBEEF, 1'b0);
        tick(2);

        // Halt word ends the load.
        start_load();
        expect_wr(9'h000, 32'h11111111);
        expect_wr(9'h004, 32'h22222222);
        expect_wr(9'h008, 32'hFFFFFFFF);
        put_word(32'h11111111, 1'b0);
        put_word(32'h22222222, 1'b0);
        chk_status("pre_halt_status", 1, 0, 0, 0);
        put_word(32'hFFFFFFFF, 1'b0);
        tick(1);
        chk_status("done_status", 0, 1, 1, 0);
        put_word(32'h33333333, 1'b0);
        tick(2);
        chk_status("done_hold_status", 0, 1, 1, 0);

        // Restart discards a partial word; a byte coinciding with the restart is dropped.
        start_load();
        chk_status("restart_from_done", 1, 0, 0, 0);
        put(8'hA1);
        put(8'hA2);
        i_rx_data    = 8'hAA;
        i_rx_valid   = 1'b1;
        i_start_load = 1'b1;
        tick(1);
        i_rx_valid   = 1'b0;
        i_start_load = 1'b0;
        expect_wr(9'h000, 32'h5060708F);
        put_word(32'h5060708F, 1'b1);
        tick(2);

        // Fill all 128 words without a halt word.
        start_load();
        for (int i = 0; i < 128; i++) begin
            w = {8'h00, 8'h11, i[7:0], 8'h5A};
            expect_wr(9'(i * 4), w);
            put_word(w, 1'b0);
        end
        tick(1);
        chk_status("overflow_status", 0, 0, 0, 1);
        put_word(32'h44444444, 1'b0);
        tick(2);
        chk_status("overflow_hold_status", 0, 0, 0, 1);

        // Asynchronous reset mid-load clears outputs without a clock edge.
        start_load();
        put(8'h77);
        put(8'h66);
        #2;
        i_reset = 1'b0;
        #1;
        chk("async_reset_outputs", {20'd0, o_dunit_w_en, o_dunit_addr, 2'd0}, 32'd0);
        chk("async_reset_data", o_dunit_data, 32'd0);
        chk_status("async_reset_status", 0, 0, 0, 0);
        @(negedge i_clk);
        i_reset = 1'b1;
        tick(3);

        chk("pending_writes", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dunit_loader.md
Name: dunit_loader

Overview:
- Program loader in the debug unit, directly upstream of the instruction fetch stage.
- Takes the byte stream from the debug UART receiver and packs it into 32-bit instruction words.
- Writes each word into the fetch-stage instruction memory through the dunit write port (w_en/addr/data).
- Holds the pipeline clock enable low while loading. Releases it once a halt word has been stored.

Parameters:
- NB_REG, 32, instruction/data word width.
- NB_WIDHT, 9, instruction memory byte-address width (512 bytes, 128 words).
- NB_BYTE, 8, width of a UART receive byte.
- HALT_WORD, 32'hFFFFFFFF, end-of-program marker word.

Ports:
- i_clk  input  1  system clock, rising-edge.
- i_reset  input  1  asynchronous, active-low reset.
- i_start_load  input  1  one-cycle pulse; starts or restarts a program load.
- i_rx_data  input  NB_BYTE  received UART byte.
- i_rx_valid  input  1  i_rx_data valid this cycle; one-cycle pulse per byte.
- o_dunit_w_en  output  1  instruction memory write strobe.
- o_dunit_addr  output  NB_WIDHT  instruction memory byte address; always word-aligned.
- o_dunit_data  output  NB_REG  instruction word to write.
- o_dunit_clk_en  output  1  pipeline clock enable (1 = run).
- o_busy  output  1  load in progress.
- o_load_done  output  1  halt word stored, program ready.
- o_overflow  output  1  memory filled before a halt word arrived.

Behaviour:
- States: IDLE, RECV, DONE, ERROR.
- Reset (i_reset=0, asynchronous):
  - state = IDLE.
  - Byte counter = 0, word address = 0, shift register = 0.
  - All outputs 0.
- IDLE:
  - rx bytes are ignored.
  - i_start_load -> RECV.
- RECV:
  - o_busy=1, o_dunit_clk_en=0.
  - Each i_rx_valid shifts the byte into the word, MSB first: the first byte lands in bits [31:24].
  - The byte counter increments 0..3 and wraps back to 0.
- Word complete (counter=3 and i_rx_valid):
  - On that same edge, register o_dunit_data = assembled word and o_dunit_addr = current word address.
  - o_dunit_w_en is high for exactly the one following cycle.
  - The word address increments by 4 on that same edge.
  - A byte arriving while w_en is high is accepted as byte 0 of the next word; there are no stall cycles.
- Halt word:
  - If the completed word == HALT_WORD, it is still written, and the state goes to DONE on the same edge.
- DONE:
  - o_load_done=1, o_dunit_clk_en=1, o_busy=0.
  - rx bytes are ignored.
- Overflow:
  - Applies when a non-halt word is completed at address 2^NB_WIDHT-4.
  - The word is written, then the state goes to ERROR.
  - The address does not wrap to 0 for a further write.
- ERROR:
  - o_overflow=1, o_dunit_clk_en=0.
  - rx bytes are ignored.
- i_start_load in any state:
  - Goes to RECV.
  - Clears the byte counter, address, o_load_done and o_overflow.
  - Clears o_dunit_clk_en on the next edge.
  - A partial word is discarded, and no write is issued for it.
- Simultaneous i_start_load and i_rx_valid: the restart wins and the byte is dropped.
- Reset mid-load: all state is lost. Memory contents already written are not touched.

Test Plan:
- Reset -> all outputs 0 and state IDLE; bytes 8'h12 ×4 sent in IDLE -> no o_dunit_w_en.
- Start load, then bytes 20,08,00,05 -> one-cycle w_en with addr=0, data=32'h20080005; a second word 8C,09,00,04 -> addr=4, data=32'h8C090004.
- Bytes sent back-to-back, every cycle, for 3 words -> w_en at addr 0, 4, 8 with no lost byte.
- Two words, then FF,FF,FF,FF -> halt written at addr 8; the next cycle o_load_done=1 and o_dunit_clk_en=1; later bytes are ignored.
- Start load, 2 bytes, then i_start_load -> no write; next 4 bytes are written at addr 0.
- 128 non-halt words -> last write at addr 0x1FC, then o_overflow=1 and clk_en=0; an asynchronous reset mid-load returns all outputs to 0 immediately, without waiting for a clock edge.
